// File: rtl/sync_fifo32.sv
// rtl/sync_fifo32.sv - single-clock 32-bit elastic FIFO between JPEG pipeline stages
// Registered read port: an accepted pop presents its word one edge later with a valid pulse.
module sync_fifo32 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_req,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  fifo_empty,
  output logic                  rdata_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_rdata_valid;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Both flags come from the pre-edge count, so a pop cannot make room for a same-cycle push.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = write_enable && !w_full;
  assign w_rd_ok = read_req && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_read_data   <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_rd_ok;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_read_data <= r_mem[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign read_data   = r_read_data;
  assign rdata_valid = r_rdata_valid;
  assign fifo_empty  = w_empty;

endmodule

// File: tb/tb_sync_fifo32.sv
// tb/tb_sync_fifo32.sv - self-checking bench for sync_fifo32 against a queue model
module tb_sync_fifo32;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        read_req;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        fifo_empty;
  logic        rdata_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] m_data;
  logic        m_valid;

  sync_fifo32 #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .read_req    (read_req),
    .write_data  (write_data),
    .write_enable(write_enable),
    .read_data   (read_data),
    .fifo_empty  (fifo_empty),
    .rdata_valid (rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model follows the pop-then-push rules on the pre-edge occupancy.
  task automatic step(input logic r, input logic we, input logic [31:0] wd, input logic rr);
    bit was_empty;
    bit was_full;
    rst = r; write_enable = we; write_data = wd; read_req = rr;
    @(posedge clk);
    #1;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    if (r) begin
      mq.delete();
      m_data  = 32'h0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (rr && !was_empty) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end
      if (we && !was_full) mq.push_back(wd);
    end
    rst = 1'b0; write_enable = 1'b0; read_req = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rdata_valid); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", read_data); end
  endtask

  task automatic test_basic_order();
    logic [31:0] vals [4];
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, vals[i], 1'b0);
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL basic_wr_empty[%0d]: got %b expected 0", i, fifo_empty); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, rdata_valid); end
      checks++; if (read_data !== vals[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, read_data, vals[i]); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse[%0d]: got %b expected 0", i, rdata_valid); end
      checks++; if (read_data !== vals[i]) begin errors++; $display("FAIL basic_hold[%0d]: got %0d expected %0d", i, read_data, vals[i]); end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_end_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_empty_read();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL emptyrd_valid: got %b expected 0", rdata_valid); end
    checks++; if (read_data !== 32'd40) begin errors++; $display("FAIL emptyrd_hold: got %0d expected 40", read_data); end
    step(1'b0, 1'b1, 32'h55, 1'b1);
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL emptyrd_bypass_valid: got %b expected 0", rdata_valid); end
    checks++; if (read_data !== 32'd40) begin errors++; $display("FAIL emptyrd_bypass_data: got %h expected 00000028", read_data); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL emptyrd_stored: got %b expected 0", fifo_empty); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (rdata_valid !== 1'b1 || read_data !== 32'h55) begin errors++; $display("FAIL emptyrd_next: got valid=%b data=%h expected valid=1 data=00000055", rdata_valid, read_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL emptyrd_last_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH + 2; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", fifo_empty); end
    // Simultaneous pop/push while full: the push of 99 must be dropped.
    step(1'b0, 1'b1, 32'd99, 1'b1);
    checks++; if (rdata_valid !== 1'b1 || read_data !== 32'd1) begin errors++; $display("FAIL ovf_full_rw: got valid=%b data=%0d expected valid=1 data=1", rdata_valid, read_data); end
    for (int i = 2; i <= DEPTH; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (rdata_valid !== 1'b1 || read_data !== 32'(i)) begin errors++; $display("FAIL ovf_read[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, rdata_valid, read_data, i); end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", fifo_empty); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (rdata_valid !== 1'b0 || read_data !== 32'(DEPTH)) begin errors++; $display("FAIL ovf_extra_read: got valid=%b data=%0d expected valid=0 data=%0d", rdata_valid, read_data, DEPTH); end
  endtask

  task automatic test_wrap_simul();
    int wr_next;
    int rd_next;
    wr_next = 1000;
    rd_next = 1000;
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b1, 32'(wr_next), 1'b0); wr_next++; end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 32'(wr_next), 1'b1);
      wr_next++;
      checks++; if (rdata_valid !== 1'b1 || read_data !== 32'(rd_next)) begin errors++; $display("FAIL wrap_seq[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, rdata_valid, read_data, rd_next); end
      rd_next++;
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL wrap_empty[%0d]: got %b expected 0", i, fifo_empty); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (read_data !== 32'(rd_next)) begin errors++; $display("FAIL wrap_drain[%0d]: got %0d expected %0d", i, read_data, rd_next); end
      rd_next++;
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_end_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(200 + i), 1'b0);
    step(1'b1, 1'b1, 32'h7, 1'b1);
    checks++; if (fifo_empty !== 1'b1 || rdata_valid !== 1'b0 || read_data !== 32'h0) begin errors++; $display("FAIL midrst_state: got empty=%b valid=%b data=%h expected empty=1 valid=0 data=00000000", fifo_empty, rdata_valid, read_data); end
    step(1'b0, 1'b1, 32'hABCD, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (rdata_valid !== 1'b1 || read_data !== 32'hABCD) begin errors++; $display("FAIL midrst_read: got valid=%b data=%h expected valid=1 data=0000abcd", rdata_valid, read_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_random();
    logic r, we, rr;
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = (i / 150) % 2;
      r  = ($urandom_range(0, 99) == 0);
      we = (bias == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      rr = (bias == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      step(r, we, $urandom, rr);
      checks++; if (rdata_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, rdata_valid, m_valid); end
      checks++; if (read_data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, read_data, m_data); end
      checks++; if (fifo_empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d]: got %b expected %b", i, fifo_empty, (mq.size() == 0)); end
    end
  endtask

  initial begin
    rst = 1'b1; read_req = 1'b0; write_enable = 1'b0; write_data = 32'h0;
    m_data = 32'h0; m_valid = 1'b0;
    test_reset();
    test_basic_order();
    test_empty_read();
    test_overflow();
    test_wrap_simul();
    test_midop_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
